tx_pkt_arbiter: RTL and testbench

- Packet-granular round-robin arbiter sharing the MAC transmit packet interface (pkt_tx_*) between two requesters, e.g. user traffic and a control/pause-frame source.
- Sits between the requesters and the MAC's tx enqueue path, in the 156.25 MHz core clock domain.
- Holds the grant from first word to eop, honours pkt_tx_full back-pressure, registers all MAC-side outputs and keeps per-port packet counters.

---
 rtl/tx_pkt_arbiter.sv | 120 ++++++++++++
 tb/tb_tx_pkt_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_arbiter.sv
// tx_pkt_arbiter: packet-granular round-robin arbiter sharing the MAC pkt_tx_* interface between two requesters
// Ports: clk_156m25, reset_156m25 (async, active high); req{0,1}_{val,sop,eop,mod,data} in, req{0,1}_rdy out;
// pkt_tx_full in; pkt_tx_{val,sop,eop,mod,data} registered out; arb_proto_err one-cycle pulse; pkt_cnt{0,1} packets per port.
// Optional TX_ARB_STALL_WATCHDOG_EN: closes a packet idle for STALL_CYCLES cycles by injecting an empty eop word.
module tx_pkt_arbiter #(
  parameter int CNT_W = 16,
  parameter int STALL_CYCLES = 64
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25,
  input  logic             req0_val,
  input  logic             req0_sop,
  input  logic             req0_eop,
  input  logic [2:0]       req0_mod,
  input  logic [63:0]      req0_data,
  output logic             req0_rdy,
  input  logic             req1_val,
  input  logic             req1_sop,
  input  logic             req1_eop,
  input  logic [2:0]       req1_mod,
  input  logic [63:0]      req1_data,
  output logic             req1_rdy,
  input  logic             pkt_tx_full,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic [63:0]      pkt_tx_data,
  output logic             arb_proto_err,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);
  typedef enum logic [1:0] {IDLE, XFER0, XFER1} state_t;
  typedef logic [$clog2(STALL_CYCLES + 1)-1:0] stall_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d, first_q, first_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [2:0] mod_q, mod_d;
  logic [63:0] data_q, data_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic gnt1, acc, inj, done, stall_fire, sel_sop, sel_eop;
  logic [2:0] sel_mod;
  logic [63:0] sel_data;
`ifdef TX_ARB_STALL_WATCHDOG_EN
  stall_t stall_q, stall_d;
  assign stall_fire = stall_q == stall_t'(STALL_CYCLES);
  // counts idle cycles of the granted port once its packet has started; saturates at the fire value
  always_comb
    stall_d = (state_q == IDLE || acc || inj) ? '0 :
              (!first_q && !(gnt1 ? req1_val : req0_val) && !stall_fire) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge clk_156m25 or posedge reset_156m25)
    if (reset_156m25) stall_q <= '0;
    else stall_q <= stall_d;
`else
  assign stall_fire = 1'b0;
`endif
  always_comb begin
    gnt1 = state_q == XFER1;
    sel_sop = gnt1 ? req1_sop : req0_sop;
    sel_eop = gnt1 ? req1_eop : req0_eop;
    sel_mod = gnt1 ? req1_mod : req0_mod;
    sel_data = gnt1 ? req1_data : req0_data;
    req0_rdy = state_q == XFER0 && !pkt_tx_full && !stall_fire;
    req1_rdy = gnt1 && !pkt_tx_full && !stall_fire;
    acc = (req0_rdy && req0_val) || (req1_rdy && req1_val);
    inj = stall_fire && !pkt_tx_full;
    done = (acc && sel_eop) || inj;
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (req0_val && req1_val) ? (last_grant_q ? XFER0 : XFER1) :
                req0_val ? XFER0 : req1_val ? XFER1 : IDLE;
    else if (done)
      state_d = IDLE;
    last_grant_d = done ? gnt1 : last_grant_q;
    first_d = state_q == IDLE ? 1'b1 : (acc ? 1'b0 : first_q);
    cnt0_d = cnt0_q + CNT_W'(done && !gnt1);
    cnt1_d = cnt1_q + CNT_W'(done && gnt1);
    val_d = acc || inj;
    // sop is regenerated from grant position, so a mismatch with the requester's sop is the protocol error
    sop_d = acc ? first_q : (inj ? 1'b0 : sop_q);
    eop_d = acc ? sel_eop : (inj ? 1'b1 : eop_q);
    mod_d = acc ? sel_mod : (inj ? 3'd0 : mod_q);
    data_d = acc ? sel_data : (inj ? 64'd0 : data_q);
    err_d = (acc && first_q != sel_sop) || inj;
  end
  always_ff @(posedge clk_156m25 or posedge reset_156m25)
    if (reset_156m25) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      first_q <= 1'b1;
      val_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      mod_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      first_q <= first_d;
      val_q <= val_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      mod_q <= mod_d;
      data_q <= data_d;
      err_q <= err_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  assign pkt_tx_val = val_q;
  assign pkt_tx_sop = sop_q;
  assign pkt_tx_eop = eop_q;
  assign pkt_tx_mod = mod_q;
  assign pkt_tx_data = data_q;
  assign arb_proto_err = err_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// tb_tx_pkt_arbiter: directed, table-driven and randomized checks of tx_pkt_arbiter
module tb_tx_pkt_arbiter;
  typedef struct packed {logic sop; logic eop; logic [2:0] mod; logic [63:0] data;} word_t;
  typedef struct {word_t w; int cyc;} obs_t;
  typedef struct {int port; int len; logic [7:0] sop_in; logic [2:0] mod; logic [7:0] exp_sop; int exp_errs; int exp_cnt0; int exp_cnt1;} vec_t;
  logic clk_156m25 = 0, reset_156m25 = 1;
  logic req0_val, req0_sop, req0_eop, req1_val, req1_sop, req1_eop, pkt_tx_full;
  logic [2:0] req0_mod, req1_mod, pkt_tx_mod;
  logic [63:0] req0_data, req1_data, pkt_tx_data;
  logic req0_rdy, req1_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, arb_proto_err;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  int checks = 0, failures = 0, cyc = 0, errs = 0, full_from = -1, full_to = -1;
  bit gaps = 0, rnd_full = 0, acc0 = 0, acc1 = 0;
  word_t q0[$], q1[$], e0[$], e1[$];
  obs_t outq[$];
  tx_pkt_arbiter dut (
    .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
    .req0_val(req0_val), .req0_sop(req0_sop), .req0_eop(req0_eop), .req0_mod(req0_mod), .req0_data(req0_data), .req0_rdy(req0_rdy),
    .req1_val(req1_val), .req1_sop(req1_sop), .req1_eop(req1_eop), .req1_mod(req1_mod), .req1_data(req1_data), .req1_rdy(req1_rdy),
    .pkt_tx_full(pkt_tx_full), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
    .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data), .arb_proto_err(arb_proto_err),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );
  always #5 clk_156m25 = ~clk_156m25;
  always @(posedge clk_156m25) cyc <= cyc + 1;
  function automatic word_t mk(input logic s, input logic e, input logic [2:0] m, input logic [63:0] d);
    word_t w;
    w.sop = s;
    w.eop = e;
    w.mod = m;
    w.data = d;
    return w;
  endfunction
  function automatic logic [127:0] all_outs();
    return {23'd0, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, req0_rdy, req1_rdy, arb_proto_err, pkt_cnt0, pkt_cnt1};
  endfunction
  always @(negedge clk_156m25) begin
    obs_t o;
    if (pkt_tx_val) begin
      o.w = mk(pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data);
      o.cyc = cyc;
      outq.push_back(o);
    end
    if (arb_proto_err) errs++;
  end
  initial begin
    {req0_val, req0_sop, req0_eop, req0_mod, req0_data} = '0;
    {req1_val, req1_sop, req1_eop, req1_mod, req1_data} = '0;
    pkt_tx_full = 0;
    forever begin
      @(negedge clk_156m25);
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      pkt_tx_full = (cyc >= full_from && cyc < full_to) || (rnd_full && $urandom_range(3) == 0);
      req0_val = q0.size() > 0 && !(gaps && $urandom_range(2) == 0);
      req1_val = q1.size() > 0 && !(gaps && $urandom_range(2) == 0);
      if (q0.size() > 0) {req0_sop, req0_eop, req0_mod, req0_data} = q0[0];
      if (q1.size() > 0) {req1_sop, req1_eop, req1_mod, req1_data} = q1[0];
      #1;
      acc0 = req0_rdy && req0_val;
      acc1 = req1_rdy && req1_val;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_pkt(input int port, input int len, input logic [63:0] base, input logic [7:0] sopm, input logic [2:0] m, input bit model);
    for (int i = 0; i < len; i++) begin
      word_t w = mk(sopm[i], i == len - 1, i == len - 1 ? m : 3'd0, base + 64'(i));
      if (port == 0) q0.push_back(w); else q1.push_back(w);
      if (model && port == 0) e0.push_back(w);
      if (model && port == 1) e1.push_back(w);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20000) begin
      @(negedge clk_156m25);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d words pending after %0d cycles, required 0", q0.size(), q1.size(), n);
    end
    repeat (6) @(negedge clk_156m25);
    #3;
  endtask
  task automatic do_reset();
    @(negedge clk_156m25);
    #3;
    reset_156m25 = 1;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk_156m25);
    #3;
    reset_156m25 = 0;
  endtask
  task automatic sync();
    @(posedge clk_156m25);
    #1;
  endtask
  initial begin
    vec_t vt[6];
    int c, n0, n1, gap, p, owner;
    bit inpkt;
    logic [7:0] sm;
    logic [63:0] base;
    logic [63:0] ord[4];
    word_t w;
    repeat (3) @(negedge clk_156m25);
    #3;
    chk("reset_outputs", all_outs(), '0);
    reset_156m25 = 0;
    // 4-word packet on port 0: latency N+2 and back-to-back streaming
    outq.delete();
    sync();
    c = cyc;
    push_pkt(0, 4, 64'h1, 8'h01, 3'd5, 0);
    wait_idle();
    chk("t1_words", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      chk("t1_cycle", outq[i].cyc, c + 2 + i);
      chk("t1_word", outq[i].w, mk(i == 0, i == 3, i == 3 ? 3'd5 : 3'd0, 64'(i + 1)));
    end
    chk("t1_cnt0", pkt_cnt0, 1);
    // simultaneous requests from reset alternate starting with port 0
    do_reset();
    outq.delete();
    sync();
    push_pkt(0, 2, 64'h100, 8'h01, 3'd0, 0);
    push_pkt(0, 2, 64'h110, 8'h01, 3'd0, 0);
    push_pkt(1, 2, 64'h200, 8'h01, 3'd0, 0);
    push_pkt(1, 2, 64'h210, 8'h01, 3'd0, 0);
    wait_idle();
    ord = '{64'h100, 64'h200, 64'h110, 64'h210};
    chk("t2_words", outq.size(), 8);
    for (int i = 0; i < 4 && 2 * i < outq.size(); i++) chk("t2_order", outq[2 * i].w.data, ord[i]);
    chk("t2_cnt0", pkt_cnt0, 2);
    chk("t2_cnt1", pkt_cnt1, 2);
    // back-pressure for 3 cycles in the middle of an 8-word packet
    outq.delete();
    sync();
    c = cyc;
    full_from = c + 4;
    full_to = c + 7;
    push_pkt(0, 8, 64'h1, 8'h01, 3'd0, 0);
    while (cyc < c + 4) @(negedge clk_156m25);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t3_rdy_low", {pkt_tx_full, req0_rdy}, 2'b10);
      @(negedge clk_156m25);
    end
    #2;
    chk("t3_rdy_resume", req0_rdy, 1);
    wait_idle();
    full_from = -1;
    full_to = -1;
    chk("t3_words", outq.size(), 8);
    for (int i = 0; i < 8 && i < outq.size(); i++) chk("t3_word", outq[i].w, mk(i == 0, i == 7, 3'd0, 64'(i + 1)));
    chk("t3_cnt0", pkt_cnt0, 3);
    // table: {port, len, input sop per word, mod, expected output sop, error pulses, counters after}
    vt[0] = '{0, 1, 8'h01, 3'd3, 8'h01, 0, 1, 0};
    vt[1] = '{1, 4, 8'h04, 3'd2, 8'h01, 2, 1, 1};
    vt[2] = '{0, 3, 8'h01, 3'd0, 8'h01, 0, 2, 1};
    vt[3] = '{1, 2, 8'h03, 3'd7, 8'h01, 1, 2, 2};
    vt[4] = '{0, 1, 8'h00, 3'd1, 8'h01, 1, 3, 2};
    vt[5] = '{1, 5, 8'h01, 3'd4, 8'h01, 0, 3, 3};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      outq.delete();
      sync();
      errs = 0;
      base = 64'(vt[k].port * 256 + k * 16);
      push_pkt(vt[k].port, vt[k].len, base, vt[k].sop_in, vt[k].mod, 0);
      wait_idle();
      chk("tbl_words", outq.size(), vt[k].len);
      sm = '0;
      foreach (outq[i]) if (i < 8) sm[i] = outq[i].w.sop;
      chk("tbl_sop", sm, vt[k].exp_sop);
      if (outq.size() > 0) begin
        chk("tbl_data0", outq[0].w.data, base);
        chk("tbl_last_eop_mod", {outq[outq.size() - 1].w.eop, outq[outq.size() - 1].w.mod}, {1'b1, vt[k].mod});
      end
      chk("tbl_err_pulses", errs, vt[k].exp_errs);
      chk("tbl_cnt0", pkt_cnt0, vt[k].exp_cnt0);
      chk("tbl_cnt1", pkt_cnt1, vt[k].exp_cnt1);
    end
    // asynchronous reset during word 3 of 6, then tie goes to port 0
    outq.delete();
    sync();
    c = cyc;
    push_pkt(0, 6, 64'h50, 8'h01, 3'd0, 0);
    while (cyc < c + 4) @(negedge clk_156m25);
    #3;
    chk("t5_word3_out", {pkt_tx_val, pkt_tx_data}, {1'b1, 64'h52});
    reset_156m25 = 1;
    #1;
    chk("t5_async_reset", all_outs(), '0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk_156m25);
    #3;
    reset_156m25 = 0;
    sync();
    outq.delete();
    push_pkt(1, 1, 64'h61, 8'h01, 3'd2, 0);
    push_pkt(0, 1, 64'h60, 8'h01, 3'd1, 0);
    wait_idle();
    chk("t5_words", outq.size(), 2);
    if (outq.size() == 2) chk("t5_tie_order", {outq[0].w.data, outq[1].w.data}, {64'h60, 64'h61});
    chk("t5_counts", {pkt_cnt0, pkt_cnt1}, {16'd1, 16'd1});
`ifdef TX_ARB_STALL_WATCHDOG_EN
    // port 0 stalls after word 2: watchdog closes the packet, then port 1 is served
    do_reset();
    outq.delete();
    sync();
    errs = 0;
    q0.push_back(mk(1'b1, 1'b0, 3'd0, 64'h70));
    q0.push_back(mk(1'b0, 1'b0, 3'd0, 64'h71));
    wait_idle();
    repeat (70) @(negedge clk_156m25);
    #3;
    chk("t6_words", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("t6_inject_word", outq[2].w, mk(1'b0, 1'b1, 3'd0, 64'd0));
      gap = outq[2].cyc - outq[1].cyc;
      chk("t6_inject_delay_65_67", gap >= 65 && gap <= 67, 1);
    end
    chk("t6_err_pulses", errs, 1);
    chk("t6_cnt0", pkt_cnt0, 1);
    outq.delete();
    sync();
    push_pkt(1, 1, 64'h80, 8'h01, 3'd0, 0);
    wait_idle();
    chk("t6_port1_served", outq.size() == 1 ? outq[0].w.data : 64'hdead, 64'h80);
`endif
    // randomized traffic with gaps and back-pressure against per-port packet queues
    do_reset();
    outq.delete();
    sync();
    errs = 0;
    gaps = 1;
    rnd_full = 1;
    n0 = $urandom_range(40, 20);
    n1 = $urandom_range(40, 20);
    for (int k = 0; k < n0; k++) push_pkt(0, $urandom_range(6, 1), {1'b0, 31'(k), 32'd0}, 8'h01, 3'($urandom_range(7)), 1);
    for (int k = 0; k < n1; k++) push_pkt(1, $urandom_range(6, 1), {1'b1, 31'(k), 32'd0}, 8'h01, 3'($urandom_range(7)), 1);
    wait_idle();
    gaps = 0;
    rnd_full = 0;
    owner = 0;
    inpkt = 0;
    foreach (outq[i]) begin
      w = outq[i].w;
      p = int'(w.data[63]);
      if (inpkt) chk("rnd_no_interleave", p, owner);
      owner = p;
      inpkt = !w.eop;
      if (p == 0 && e0.size() > 0) chk("rnd_word_p0", w, e0.pop_front());
      else if (p == 1 && e1.size() > 0) chk("rnd_word_p1", w, e1.pop_front());
      else begin
        checks++;
        failures++;
        $display("FAIL rnd_extra_word: got %0h from port %0d, expected no further words", w.data, p);
      end
    end
    chk("rnd_missing", {e0.size(), e1.size()}, 64'd0);
    chk("rnd_cnt0", pkt_cnt0, n0);
    chk("rnd_cnt1", pkt_cnt1, n1);
    chk("rnd_no_err", errs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
